// File: rtl/dcache_arbiter.sv
// dcache_arbiter: registered single-port arbiter for host, processor and display access to the data cache.
// Optional macro DCACHE_ARB_RR_EN selects round-robin arbitration; the default build is fixed priority host > proc > disp.

module dcache_arbiter #(
  parameter int DMEM_SZ    = 9,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req_in,
  input  logic [ADDR_W-1:0] host_addr_in,
  input  logic [DATA_W-1:0] host_data_in,
  output logic              host_gnt_out,
  input  logic              proc_req_in,
  input  logic              proc_we_in,
  input  logic [ADDR_W-1:0] proc_addr_in,
  input  logic [DATA_W-1:0] proc_data_in,
  input  logic              proc_lock_in,
  output logic              proc_gnt_out,
  input  logic              disp_req_in,
  input  logic [ADDR_W-1:0] disp_addr_in,
  output logic              disp_gnt_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_wen_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rvalid_out,
  output logic [1:0]        rsrc_out,
  output logic              err_out
);

  localparam int HOST = 0;
  localparam int PROC = 1;
  localparam int DISP = 2;
  localparam logic [ADDR_W:0] SZ  = (ADDR_W+1)'(DMEM_SZ);
  localparam logic [3:0]      LIM = 4'(STARVE_LIM);

  logic [2:0]        r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_we;
  logic              r_inrange;
  logic [3:0]        r_wait;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic [1:0]        r_rsrc;
  logic              r_err;

  logic [2:0]        w_req;
  logic [2:0]        w_elig;
  logic [2:0]        w_win;
  logic              w_starve;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_we;
  logic              w_busy;
  logic              w_rd;

  // A requester holding req through its own grant cycle is not a new request.
  assign w_req    = {disp_req_in, proc_req_in, host_req_in & ~proc_lock_in};
  assign w_elig   = w_req & ~r_gnt;
  assign w_starve = (r_wait >= LIM);

`ifdef DCACHE_ARB_RR_EN
  logic [1:0] r_ptr;

  always_comb begin
    w_win = 3'b000;
    if (w_elig[DISP] && w_starve) begin
      w_win = 3'b100;
    end else begin
      case (r_ptr)
        2'd0: begin
          if (w_elig[HOST])      w_win = 3'b001;
          else if (w_elig[PROC]) w_win = 3'b010;
          else if (w_elig[DISP]) w_win = 3'b100;
        end
        2'd1: begin
          if (w_elig[PROC])      w_win = 3'b010;
          else if (w_elig[DISP]) w_win = 3'b100;
          else if (w_elig[HOST]) w_win = 3'b001;
        end
        default: begin
          if (w_elig[DISP])      w_win = 3'b100;
          else if (w_elig[HOST]) w_win = 3'b001;
          else if (w_elig[PROC]) w_win = 3'b010;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              r_ptr <= 2'd0;
    else if (w_win[HOST]) r_ptr <= 2'd1;
    else if (w_win[PROC]) r_ptr <= 2'd2;
    else if (w_win[DISP]) r_ptr <= 2'd0;
  end
`else
  always_comb begin
    w_win = 3'b000;
    if (w_elig[DISP] && w_starve) w_win = 3'b100;
    else if (w_elig[HOST])        w_win = 3'b001;
    else if (w_elig[PROC])        w_win = 3'b010;
    else if (w_elig[DISP])        w_win = 3'b100;
  end
`endif

  always_comb begin
    w_sel_addr = disp_addr_in;
    w_sel_data = '0;
    w_sel_we   = 1'b0;
    if (w_win[HOST]) begin
      w_sel_addr = host_addr_in;
      w_sel_data = host_data_in;
      w_sel_we   = 1'b1;
    end else if (w_win[PROC]) begin
      w_sel_addr = proc_addr_in;
      w_sel_data = proc_data_in;
      w_sel_we   = proc_we_in;
    end
  end

  assign w_busy = |r_gnt;
  assign w_rd   = w_busy & ~r_we;

  assign host_gnt_out = r_gnt[HOST];
  assign proc_gnt_out = r_gnt[PROC];
  assign disp_gnt_out = r_gnt[DISP];
  // Idle cycles pass the display address straight through to the cache.
  assign mem_addr_out = w_busy ? r_addr : disp_addr_in;
  assign mem_data_out = r_data;
  assign mem_wen_out  = w_busy & r_we & r_inrange & ~rst;
  assign rdata_out    = r_rdata;
  assign rvalid_out   = r_rvalid;
  assign rsrc_out     = r_rsrc;
  assign err_out      = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= 3'b000;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_inrange <= 1'b0;
      r_wait    <= 4'd0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_rsrc    <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      r_gnt <= w_win;
      if (|w_win) begin
        r_addr    <= w_sel_addr;
        r_data    <= w_sel_data;
        r_we      <= w_sel_we;
        r_inrange <= ({1'b0, w_sel_addr} < SZ);
      end
      r_rvalid <= w_rd;
      r_rsrc   <= w_rd ? (r_gnt[DISP] ? 2'b10 : 2'b01) : 2'b00;
      if (w_rd) r_rdata <= r_inrange ? mem_data_in : '0;
      r_err <= w_busy & ~r_inrange;
      if (!disp_req_in || r_gnt[DISP]) r_wait <= 4'd0;
      else if (r_wait < LIM)           r_wait <= r_wait + 4'd1;
    end
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed table of per-cycle stimulus/expectations for dcache_arbiter,
// plus a continuous-contention sequence for starvation (fixed priority) or rotation (DCACHE_ARB_RR_EN).

module tb_dcache_arbiter;

  logic       clk;
  logic       rst;
  logic       host_req_in;
  logic [3:0] host_addr_in;
  logic [7:0] host_data_in;
  logic       host_gnt_out;
  logic       proc_req_in;
  logic       proc_we_in;
  logic [3:0] proc_addr_in;
  logic [7:0] proc_data_in;
  logic       proc_lock_in;
  logic       proc_gnt_out;
  logic       disp_req_in;
  logic [3:0] disp_addr_in;
  logic       disp_gnt_out;
  logic [3:0] mem_addr_out;
  logic [7:0] mem_data_out;
  logic       mem_wen_out;
  logic [7:0] mem_data_in;
  logic [7:0] rdata_out;
  logic       rvalid_out;
  logic [1:0] rsrc_out;
  logic       err_out;

  int errors = 0;
  int checks = 0;

  dcache_arbiter #(.DMEM_SZ(9), .ADDR_W(4), .DATA_W(8), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst),
    .host_req_in(host_req_in), .host_addr_in(host_addr_in), .host_data_in(host_data_in),
    .host_gnt_out(host_gnt_out),
    .proc_req_in(proc_req_in), .proc_we_in(proc_we_in), .proc_addr_in(proc_addr_in),
    .proc_data_in(proc_data_in), .proc_lock_in(proc_lock_in), .proc_gnt_out(proc_gnt_out),
    .disp_req_in(disp_req_in), .disp_addr_in(disp_addr_in), .disp_gnt_out(disp_gnt_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_wen_out(mem_wen_out),
    .mem_data_in(mem_data_in), .rdata_out(rdata_out), .rvalid_out(rvalid_out),
    .rsrc_out(rsrc_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: 16 physical words so any stray out-of-range write or unmasked read is visible.
  logic [7:0] cache_m [16];
  initial for (int i = 0; i < 16; i++) cache_m[i] = 8'h10 + 8'(i);
  always @(posedge clk) if (mem_wen_out) cache_m[mem_addr_out] <= mem_data_out;
  assign mem_data_in = cache_m[mem_addr_out];

  typedef struct {
    logic       rst;
    logic       h;  logic [3:0] ha; logic [7:0] hd;
    logic       p;  logic pwe; logic [3:0] pa; logic [7:0] pd;
    logic       lk;
    logic       d;  logic [3:0] da;
    logic [2:0] g;
    logic       wen; logic [3:0] a;
    logic       rv; logic [1:0] rs; logic [7:0] rd;
    logic       err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic h, input logic [3:0] ha, input logic [7:0] hd,
                              input logic p, input logic pwe, input logic [3:0] pa, input logic [7:0] pd,
                              input logic lk, input logic d, input logic [3:0] da,
                              input logic [2:0] g, input logic wen, input logic [3:0] a,
                              input logic rv, input logic [1:0] rs, input logic [7:0] rd, input logic err);
    vec_t t;
    t.rst = r; t.h = h; t.ha = ha; t.hd = hd;
    t.p = p; t.pwe = pwe; t.pa = pa; t.pd = pd;
    t.lk = lk; t.d = d; t.da = da;
    t.g = g; t.wen = wen; t.a = a;
    t.rv = rv; t.rs = rs; t.rd = rd; t.err = err;
    vq.push_back(t);
  endfunction

  vec_t       v;
  logic [9:0] got_v;
  logic [9:0] exp_v;
  logic       ok;
  logic [2:0] exp_g [9];
  logic [2:0] got_g;

  initial begin
    rst = 1'b1;
    host_req_in = 0; host_addr_in = 0; host_data_in = 0;
    proc_req_in = 0; proc_we_in = 0; proc_addr_in = 0; proc_data_in = 0; proc_lock_in = 0;
    disp_req_in = 0; disp_addr_in = 0;

    //  rst  h ha  hd     p we pa   pd     lk d da     g    wen a    rv rs     rd     err
    add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 0); // reset state
    add(0, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 0); // c0 host write req
    add(0, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0, 3'b001, 1, 3, 0, 2'b00, 8'h00, 0); // c1 host grant
    add(0, 0, 3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 3, 3'b000, 0, 3, 0, 2'b00, 8'h00, 0); // disp read 3
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 3, 3'b100, 0, 3, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 3, 3'b000, 0, 3, 1, 2'b10, 8'hA5, 0);
    add(0, 1, 1, 8'h5A, 1, 0, 2, 8'h00, 0, 1, 5, 3'b000, 0, 5, 0, 2'b00, 8'h00, 0); // all three request
    add(0, 1, 1, 8'h5A, 1, 0, 2, 8'h00, 0, 1, 5, 3'b001, 1, 1, 0, 2'b00, 8'h00, 0);
    add(0, 0, 1, 8'h5A, 1, 0, 2, 8'h00, 0, 1, 5, 3'b010, 0, 2, 0, 2'b00, 8'h00, 0);
    add(0, 0, 1, 8'h5A, 0, 0, 2, 8'h00, 0, 1, 5, 3'b100, 0, 5, 1, 2'b01, 8'h12, 0);
    add(0, 0, 1, 8'h5A, 0, 0, 2, 8'h00, 0, 0, 5, 3'b000, 0, 5, 1, 2'b10, 8'h15, 0);
    add(0, 1, 4, 8'h77, 1, 0, 0, 8'h00, 1, 0, 5, 3'b000, 0, 5, 0, 2'b00, 8'h00, 0); // lock on
    add(0, 1, 4, 8'h77, 1, 0, 0, 8'h00, 1, 0, 5, 3'b010, 0, 0, 0, 2'b00, 8'h00, 0);
    add(0, 1, 4, 8'h77, 1, 0, 0, 8'h00, 1, 0, 5, 3'b000, 0, 5, 1, 2'b01, 8'h10, 0);
    add(0, 1, 4, 8'h77, 1, 0, 0, 8'h00, 0, 0, 5, 3'b010, 0, 0, 0, 2'b00, 8'h00, 0); // lock off
    add(0, 1, 4, 8'h77, 1, 0, 0, 8'h00, 0, 0, 5, 3'b001, 1, 4, 1, 2'b01, 8'h10, 0);
    add(0, 0, 4, 8'h77, 1, 0, 0, 8'h00, 0, 0, 5, 3'b010, 0, 0, 0, 2'b00, 8'h00, 0);
    add(0, 0, 4, 8'h77, 0, 0, 0, 8'h00, 0, 0, 5, 3'b000, 0, 5, 1, 2'b01, 8'h10, 0);
    add(0, 0, 0, 8'h00, 1, 1, 9, 8'h33, 0, 0, 5, 3'b000, 0, 5, 0, 2'b00, 8'h00, 0); // store addr 9
    add(0, 0, 0, 8'h00, 1, 1, 9, 8'h33, 0, 0, 5, 3'b010, 0, 9, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 1, 9, 8'h33, 0, 0, 5, 3'b000, 0, 5, 0, 2'b00, 8'h00, 1);
    add(0, 0, 0, 8'h00, 1, 0, 12, 8'h00, 0, 0, 5, 3'b000, 0, 5, 0, 2'b00, 8'h00, 0); // load addr 12
    add(0, 0, 0, 8'h00, 1, 0, 12, 8'h00, 0, 0, 5, 3'b010, 0, 12, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 12, 8'h00, 0, 0, 5, 3'b000, 0, 5, 1, 2'b01, 8'h00, 1);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 4, 3'b000, 0, 4, 0, 2'b00, 8'h00, 0); // disp read 4
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 4, 3'b100, 0, 4, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 4, 3'b000, 0, 4, 1, 2'b10, 8'h77, 0);
    add(0, 1, 6, 8'hC3, 0, 0, 0, 8'h00, 0, 0, 4, 3'b000, 0, 4, 0, 2'b00, 8'h00, 0); // host write 6
    add(1, 1, 6, 8'hC3, 0, 0, 0, 8'h00, 0, 0, 4, 3'b001, 0, 6, 0, 2'b00, 8'h00, 0); // rst in grant
    add(0, 0, 6, 8'hC3, 0, 0, 0, 8'h00, 0, 0, 4, 3'b000, 0, 4, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 6, 3'b000, 0, 6, 0, 2'b00, 8'h00, 0); // entry 6 intact
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 6, 3'b100, 0, 6, 0, 2'b00, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 6, 3'b000, 0, 6, 1, 2'b10, 8'h16, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 6, 3'b000, 0, 6, 0, 2'b00, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 6, 3'b100, 0, 6, 0, 2'b00, 8'h00, 0); // rst in read grant
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 6, 3'b000, 0, 6, 0, 2'b00, 8'h00, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rst = v.rst;
      host_req_in = v.h; host_addr_in = v.ha; host_data_in = v.hd;
      proc_req_in = v.p; proc_we_in = v.pwe; proc_addr_in = v.pa; proc_data_in = v.pd;
      proc_lock_in = v.lk; disp_req_in = v.d; disp_addr_in = v.da;
      #1;
      got_v = {disp_gnt_out, proc_gnt_out, host_gnt_out, mem_wen_out, mem_addr_out, rvalid_out, err_out};
      exp_v = {v.g, v.wen, v.a, v.rv, v.err};
      ok = (got_v == exp_v) && (!v.rv || (rdata_out == v.rd && rsrc_out == v.rs));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d: got gnt=%b wen=%b addr=%h rvalid=%b err=%b rdata=%h rsrc=%b; want gnt=%b wen=%b addr=%h rvalid=%b err=%b rdata=%h rsrc=%b",
                 i, got_v[9:7], got_v[6], got_v[5:2], got_v[1], got_v[0], rdata_out, rsrc_out,
                 v.g, v.wen, v.a, v.rv, v.err, v.rd, v.rs);
      end
      @(posedge clk);
      #1;
    end

    // Continuous contention from all three requesters; grants as {disp,proc,host} for cycles 1..9.
`ifdef DCACHE_ARB_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_g = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b100};
`endif
    rst = 1'b1;
    host_req_in = 0; proc_req_in = 0; disp_req_in = 0; proc_lock_in = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    host_req_in = 1; host_addr_in = 7; host_data_in = 8'h00;
    proc_req_in = 1; proc_we_in = 0; proc_addr_in = 0;
    disp_req_in = 1; disp_addr_in = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      got_g = {disp_gnt_out, proc_gnt_out, host_gnt_out};
      checks++;
      if (got_g != exp_g[k]) begin
        errors++;
        $display("FAIL contention cycle %0d: got gnt=%b want gnt=%b", k + 1, got_g, exp_g[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
# dcache_arbiter

Single-port arbiter for the 9-entry data cache, shared by three requesters: the SPI host loader, processor store/load, and the seven-segment readout. It replaces ad-hoc address/data muxing in front of the data cache with a registered grant, write/read sequencing, display starvation protection, and out-of-range address protection. It sits between the control logic/shift-register buffer and the `cache` instance.

## Interface
Parameters:
- `DMEM_SZ`, 9: number of valid data-cache entries.
- `ADDR_W`, 4: address width.
- `DATA_W`, 8: data width.
- `STARVE_LIM`, 8: display wait cycles before forced priority (1..15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `host_req_in` in 1: host write request.
- `host_addr_in` in ADDR_W: host address.
- `host_data_in` in DATA_W: host write data.
- `host_gnt_out` out 1: host grant pulse.
- `proc_req_in` in 1: processor request.
- `proc_we_in` in 1: 1 = store, 0 = load.
- `proc_addr_in` in ADDR_W: processor address.
- `proc_data_in` in DATA_W: processor store data (accumulator).
- `proc_lock_in` in 1: processor executing; blocks host grants.
- `proc_gnt_out` out 1: processor grant pulse.
- `disp_req_in` in 1: display read request.
- `disp_addr_in` in ADDR_W: display address.
- `disp_gnt_out` out 1: display grant pulse.
- `mem_addr_out` out ADDR_W: cache address.
- `mem_data_out` out DATA_W: cache write data.
- `mem_wen_out` out 1: cache write enable.
- `mem_data_in` in DATA_W: cache combinational read data.
- `rdata_out` out DATA_W: registered read data.
- `rvalid_out` out 1: read data valid, one pulse per read.
- `rsrc_out` out 2: read owner: 01 = proc, 10 = disp.
- `err_out` out 1: out-of-range access pulse.

## Operation
- Requests are level, held by the requester until its grant is seen.
- The grant decision is registered. At each edge the arbiter selects at most one requester from those with `req` high. A requester whose grant is high in the current cycle is excluded. Winner's address, data and we are latched on the same edge.
- Grant cycle (one cycle, `*_gnt_out` = 1):
  - `mem_addr_out`/`mem_data_out` drive the latched values.
  - `mem_wen_out` = latched write & in-range & ~rst.
- Idle: `mem_addr_out` = `disp_addr_in`, `mem_wen_out` = 0. This keeps the display path transparent.
- Reads (proc load, disp): `mem_data_in` is captured into `rdata_out` at the end of the grant cycle. `rvalid_out` and `rsrc_out` are high the next cycle.
- Priority (default): host > proc > disp.
  - `proc_lock_in` = 1 removes host from eligibility. The host request stays pending.
  - Starvation: a 4-bit wait counter increments each cycle `disp_req_in` is high and not granted. It clears on disp grant or when `disp_req_in` is low. When it reaches `STARVE_LIM`, disp wins the next decision over all others, and the counter saturates until then.
- Range check: address ≥ `DMEM_SZ`.
  - Write is suppressed.
  - Read returns `8'h00`.
  - `err_out` pulses in the cycle after the grant. Grant is still issued.
- Reset values: all grants 0, `mem_wen_out` 0, `rdata_out` 0, `rvalid_out` 0, `rsrc_out` 0, `err_out` 0, wait counter 0, RR pointer = host.

## Timing
- Request high at cycle 0 with no contention: grant in cycle 1, write takes effect at end of cycle 1, `rvalid_out` in cycle 2.
- Back-to-back grants to different requesters are allowed every cycle. The same requester gets at most one grant every 2 cycles.
- If a requester holds `req` in the cycle of its grant, that does not re-request; only `req` still high in the cycle after grant counts as new.
- Simultaneous host/proc/disp requests at cycle 0: host in cycle 1, proc in cycle 2, disp in cycle 3 (absent lock/starvation).
- `rst` asserted during a grant cycle: write suppressed, no `rvalid_out` follows, all state cleared next cycle.
- `proc_lock_in` rising while a host grant is already registered: that grant completes. Lock gates only subsequent decisions.

## Configuration
- `DCACHE_ARB_RR_EN` defined: fixed priority is replaced by round-robin. Order is host → proc → disp. The pointer advances to the requester after the last winner. Lock and starvation rules still apply, and starvation override still takes precedence.
- `DCACHE_ARB_RR_EN` undefined: fixed priority host > proc > disp. No pointer register is built.

## Test plan
- Host writes 8'hA5 to addr 3, no contention → `host_gnt_out` in cycle 1, `mem_wen_out`=1, addr 3; later disp read addr 3 → `rdata_out`=8'hA5, `rsrc_out`=10.
- Host, proc-load addr 2, disp addr 5 all request at cycle 0 → grants in cycles 1, 2, 3; two `rvalid_out` pulses in cycles 3 and 4.
- `proc_lock_in`=1 with host and proc requesting continuously → only proc grants while locked; host granted the cycle after lock drops.
- Host and proc request continuously with `STARVE_LIM`=8 and disp requesting → disp granted no later than cycle 10 after its request.
- Proc store to addr 9 → grant issued, `mem_wen_out`=0, `err_out` pulse next cycle; proc load addr 12 → `rdata_out`=8'h00, `err_out`=1.
- `rst` during a host write grant → cache entry unchanged, all outputs 0 next cycle. With `DCACHE_ARB_RR_EN` and all three requesting continuously, grants rotate host, proc, disp.
